instruction_fetch_stage: RTL and testbench

- IF stage of the pipelined core; the requesting side of the instruction-memory read interface.
- Owns the PC, drives the byte address to the combinational instruction memory, and captures the returned word into the IF/ID pipeline register.
- Handles the decode stage's hazard stall, the execute stage's branch/jump redirect (flush), and end-of-program detection.
- Instruction memory is byte-addressed and word-populated at multiples of 4; the last populated address is 72.

---
 rtl/core_pkg.sv | 11 +
 rtl/pc_register.sv | 20 ++
 rtl/instruction_fetch_stage.sv | 56 +++++
 tb/tb_instruction_fetch_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: constants and the IF/ID pipeline register type shared across pipeline stages.
package core_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [31:0] RESET_PC = 32'd0;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic valid;
  } ifid_t;
endpackage

// File: rtl/pc_register.sv
// pc_register: program counter with flush/stall/increment/hold selection and end-of-program compare.
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] LAST_PC = 32'd72
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        done
);
  assign done = pc > LAST_PC;
  // Once past the last instruction the PC parks so memory beyond the program is never addressed further.
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= RESET_PC;
    else if (flush) pc <= {redirect_pc[31:2], 2'b00};
    else if (!stall && !done) pc <= pc + 32'd4;
endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: drives the instruction memory from the PC and captures fetched words into IF/ID.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = core_pkg::RESET_PC,
  parameter logic [31:0] LAST_PC = 32'd72,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        done,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);
  import core_pkg::*;
  localparam ifid_t BUBBLE = '{pc: 32'd0, pc_plus4: 32'd0, instr: NOP_INSTR, valid: 1'b0};
  logic [31:0] pc;
  ifid_t ifid;
  pc_register #(.RESET_PC(RESET_PC), .LAST_PC(LAST_PC)) u_pc (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .redirect_pc(redirect_pc),
    .pc(pc),
    .done(done)
  );
  assign imem_addr = pc;
  assign ifid_pc = ifid.pc;
  assign ifid_pc_plus4 = ifid.pc_plus4;
  assign ifid_instr = ifid.instr;
  assign ifid_valid = ifid.valid;
  // The memory word is only sampled while in range, so out-of-program contents never enter the pipeline.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ifid <= BUBBLE;
      misalign_err <= 1'b0;
      fetch_count <= 32'd0;
    end else if (flush) begin
      ifid <= BUBBLE;
      misalign_err <= misalign_err | (|redirect_pc[1:0]);
    end else if (!stall) begin
      if (done) ifid <= BUBBLE;
      else begin
        ifid <= '{pc: pc, pc_plus4: pc + 32'd4, instr: imem_instr, valid: 1'b1};
        fetch_count <= fetch_count + 32'd1;
      end
    end
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed and randomized checks of the fetch stage against a behavioural model.
module tb_instruction_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr, imem_instr, ifid_pc, ifid_pc_plus4, ifid_instr, fetch_count;
  logic ifid_valid, done, misalign_err;
  logic [31:0] mem [0:18];
  int checks = 0;
  int passed = 0;
  logic [31:0] m_pc, m_ipc, m_ip4, m_instr, m_cnt;
  logic m_valid, m_err;

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr <= 32'd72) ? mem[imem_addr[6:2]] : 32'hDEADBEEF;

  instruction_fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .redirect_pc(redirect_pc),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid),
    .done(done),
    .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic bubble();
    m_ipc = 32'd0;
    m_ip4 = 32'd0;
    m_instr = 32'h00000013;
    m_valid = 1'b0;
  endtask

  // Reference model: what the stage must hold after each edge, computed from the fetch rules.
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_pc = 32'd0;
      m_cnt = 32'd0;
      m_err = 1'b0;
      bubble();
    end else if (flush) begin
      m_err = m_err | (redirect_pc % 4 != 0);
      m_pc = redirect_pc - redirect_pc % 4;
      bubble();
    end else if (!stall) begin
      if (m_pc <= 32'd72) begin
        m_ipc = m_pc;
        m_ip4 = m_pc + 32'd4;
        m_instr = mem[m_pc / 4];
        m_valid = 1'b1;
        m_cnt = m_cnt + 32'd1;
        m_pc = m_pc + 32'd4;
      end else bubble();
    end

  always @(negedge clk) begin
    chk("imem_addr", imem_addr, m_pc);
    chk("done", 32'(done), 32'(m_pc > 32'd72));
    chk("ifid_pc", ifid_pc, m_ipc);
    chk("ifid_pc_plus4", ifid_pc_plus4, m_ip4);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
    chk("misalign_err", 32'(misalign_err), 32'(m_err));
    chk("fetch_count", fetch_count, m_cnt);
  end

  task automatic step(input logic s, input logic f, input logic [31:0] r);
    stall = s;
    flush = f;
    redirect_pc = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 19; i++) mem[i] = 32'h10000000 + 32'(i) * 32'h01010101;
    mem[0] = 32'h00B08133;
    mem[1] = 32'h00A10093;
    mem[2] = 32'h0000A183;
    mem[3] = 32'h001182B3;
    mem[8] = 32'h01400B13;
    mem[18] = 32'h004D9A93;
    #1 reset = 1'b1;
    #1;
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_ifid_instr", ifid_instr, 32'h00000013);
    chk("rst_fetch_count", fetch_count, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    step(0, 0, 0);
    chk("seq0", ifid_instr, 32'h00B08133);
    step(0, 0, 0);
    chk("seq1", ifid_instr, 32'h00A10093);
    step(0, 0, 0);
    chk("seq2", ifid_instr, 32'h0000A183);
    chk("seq_count", fetch_count, 32'd3);
    chk("seq_addr", imem_addr, 32'd12);
    step(1, 0, 0);
    chk("stall_addr", imem_addr, 32'd12);
    chk("stall_ifid_pc", ifid_pc, 32'd8);
    step(1, 0, 0);
    chk("stall2_addr", imem_addr, 32'd12);
    chk("stall2_instr", ifid_instr, 32'h0000A183);
    chk("stall2_count", fetch_count, 32'd3);
    step(0, 0, 0);
    chk("release_instr", ifid_instr, 32'h001182B3);
    chk("release_pc", ifid_pc, 32'd12);
    step(0, 0, 0);
    chk("pre_flush_addr", imem_addr, 32'd20);
    step(0, 1, 32);
    chk("flush_valid", 32'(ifid_valid), 32'd0);
    chk("flush_instr", ifid_instr, 32'h00000013);
    chk("flush_addr", imem_addr, 32'd32);
    step(0, 0, 0);
    chk("target_instr", ifid_instr, 32'h01400B13);
    chk("target_pc", ifid_pc, 32'd32);
    chk("target_pc4", ifid_pc_plus4, 32'd36);
    step(1, 1, 28);
    chk("fs_addr", imem_addr, 32'd28);
    chk("fs_valid", 32'(ifid_valid), 32'd0);
    reset = 1'b1;
    step(0, 0, 0);
    reset = 1'b0;
    repeat (19) step(0, 0, 0);
    chk("end_ifid_pc", ifid_pc, 32'd72);
    chk("end_instr", ifid_instr, 32'h004D9A93);
    chk("end_count", fetch_count, 32'd19);
    chk("end_done", 32'(done), 32'd1);
    chk("end_addr", imem_addr, 32'd76);
    step(0, 0, 0);
    chk("park_valid", 32'(ifid_valid), 32'd0);
    chk("park_addr", imem_addr, 32'd76);
    chk("park_count", fetch_count, 32'd19);
    chk("park_instr", ifid_instr, 32'h00000013);
    step(0, 1, 34);
    chk("mis_addr", imem_addr, 32'd32);
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_done", 32'(done), 32'd0);
    step(0, 1, 8);
    chk("mis_sticky", 32'(misalign_err), 32'd1);
    chk("mis_addr2", imem_addr, 32'd8);
    step(1, 0, 0);
    step(1, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_err", 32'(misalign_err), 32'd0);
    chk("async_addr", imem_addr, 32'd0);
    chk("async_count", fetch_count, 32'd0);
    chk("async_valid", 32'(ifid_valid), 32'd0);
    chk("async_instr", ifid_instr, 32'h00000013);
    chk("async_pc", ifid_pc, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    stall = 1'b0;
    repeat (3000) begin
      logic [31:0] r;
      r = 32'($urandom_range(0, 26)) * 32'd4;
      if ($urandom_range(0, 7) == 0) r = r | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
      step(1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 10), r);
      reset = 1'b0;
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
